rom_fetch_sched: RTL and testbench

Schedules all ROM traffic onto one toggle-handshake SDRAM port, in the `clk_sys` domain.
- Shares the port between the byte-wide download stream and up to `NCLIENTS` word-address read clients (CPU ROMs, tile ROMs).
- Holds one fetched word per client.
- Sits between the `data_io` download interface / core ROM address buses and a single `sdram` port.

---
 rtl/rom_fetch_sched.sv | 211 +++++++++++++++++++++
 tb/tb_rom_fetch_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_sched.sv
// Schedules download byte writes and per-client ROM word reads onto one toggle-handshake SDRAM port.
// Build option: define ROMSCHED_FIXED_PRIO_EN for lowest-index-wins client arbitration instead of round-robin.
module rom_fetch_sched #(
  parameter int NCLIENTS = 6,
  parameter int AW       = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     dl_active,
  input  logic                     dl_wr,
  input  logic [23:0]              dl_addr,
  input  logic [7:0]               dl_data,
  input  logic [NCLIENTS*AW-1:0]   cli_addr,
  output logic [NCLIENTS*16-1:0]   cli_q,
  output logic [NCLIENTS-1:0]      cli_valid,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic                     mem_we,
  output logic [22:0]              mem_a,
  output logic [1:0]               mem_ds,
  output logic [15:0]              mem_d,
  input  logic [15:0]              mem_q,
  output logic                     busy,
  output logic                     dl_overflow
);
  localparam int IW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;

  logic          mem_req_q, mem_we_q;
  logic [22:0]   mem_a_q;
  logic [1:0]    mem_ds_q;
  logic [15:0]   mem_d_q;
  logic          dl_wr_q, dl_active_q, overflow_q;

  logic [23:0]   fifo_addr_q [2];
  logic [7:0]    fifo_data_q [2];
  logic          fifo_wr_ptr_q, fifo_rd_ptr_q;
  logic [1:0]    fifo_cnt_q;
  logic          push, accept;

  logic [AW-1:0] tag_q   [NCLIENTS];
  logic [15:0]   cli_q_q [NCLIENTS];
  logic [NCLIENTS-1:0] tag_v_q;
  logic [AW-1:0] cli_addr_a [NCLIENTS];
  logic [NCLIENTS-1:0] pend;

  logic [IW-1:0] gnt_q;
  logic [AW-1:0] gnt_addr_q;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          issue_wr, issue_rd, done;

  for (genvar gi = 0; gi < NCLIENTS; gi++) begin : g_cli
    assign cli_addr_a[gi]       = cli_addr[gi*AW +: AW];
    assign cli_valid[gi]        = tag_v_q[gi] & (tag_q[gi] == cli_addr_a[gi]);
    assign cli_q[gi*16 +: 16]   = cli_q_q[gi];
  end
  assign pend = ~cli_valid;

`ifdef ROMSCHED_FIXED_PRIO_EN
  always_comb begin
    logic [IW-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NCLIENTS - 1; k >= 0; k--) begin
      cand = IW'(k);
      if (pend[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end
`else
  logic [IW-1:0] rr_q;

  // Search begins one past the last read grant and wraps modulo NCLIENTS.
  always_comb begin
    logic [IW-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NCLIENTS; k++) begin
      cand = IW'((int'(rr_q) + k) % NCLIENTS);
      if (!pick_found && pend[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rr_q <= IW'(NCLIENTS - 1);
    end else if (issue_rd) begin
      rr_q <= pick_idx;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_cnt_q != 2'd0) begin
          issue_wr = 1'b1;
          state_d  = WAIT;
        end else if (!dl_active && pick_found) begin
          issue_rd = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack == mem_req_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request toggle re-syncs to the ack on reset so an abandoned transaction's late ack is harmless.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_req_q  <= mem_ack;
      mem_we_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_ds_q   <= 2'b11;
      mem_d_q    <= '0;
      gnt_q      <= '0;
      gnt_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue_wr) begin
        mem_req_q <= ~mem_req_q;
        mem_we_q  <= 1'b1;
        mem_a_q   <= fifo_addr_q[fifo_rd_ptr_q][23:1];
        mem_ds_q  <= {fifo_addr_q[fifo_rd_ptr_q][0], ~fifo_addr_q[fifo_rd_ptr_q][0]};
        mem_d_q   <= {fifo_data_q[fifo_rd_ptr_q], fifo_data_q[fifo_rd_ptr_q]};
      end else if (issue_rd) begin
        mem_req_q  <= ~mem_req_q;
        mem_we_q   <= 1'b0;
        mem_a_q    <= 23'(cli_addr_a[pick_idx]);
        mem_ds_q   <= 2'b11;
        gnt_q      <= pick_idx;
        gnt_addr_q <= cli_addr_a[pick_idx];
      end
    end
  end

  assign push   = dl_wr & ~dl_wr_q;
  assign accept = push & ((fifo_cnt_q != 2'd2) | issue_wr);

  always_ff @(posedge clk_sys) begin
    if (accept) begin
      fifo_addr_q[fifo_wr_ptr_q] <= dl_addr;
      fifo_data_q[fifo_wr_ptr_q] <= dl_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      overflow_q    <= 1'b0;
      dl_wr_q       <= 1'b0;
      dl_active_q   <= dl_active;
    end else begin
      dl_wr_q     <= dl_wr;
      dl_active_q <= dl_active;
      if (accept)   fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
      if (issue_wr) fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(accept) - 2'(issue_wr);
      if (push && !accept) overflow_q <= 1'b1;
    end
  end

  // A dl_active edge must win over a same-cycle read completion so stale data is never marked valid.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tag_v_q <= '0;
      for (int i = 0; i < NCLIENTS; i++) begin
        tag_q[i]   <= '0;
        cli_q_q[i] <= '0;
      end
    end else begin
      if (done && !mem_we_q) begin
        cli_q_q[gnt_q] <= mem_q;
        tag_q[gnt_q]   <= gnt_addr_q;
        tag_v_q[gnt_q] <= 1'b1;
      end
      if (dl_active ^ dl_active_q) tag_v_q <= '0;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_a       = mem_a_q;
  assign mem_ds      = mem_ds_q;
  assign mem_d       = mem_d_q;
  assign busy        = (state_q == WAIT);
  assign dl_overflow = overflow_q;
endmodule

// File: tb/tb_rom_fetch_sched.sv
// Randomized bench for rom_fetch_sched: a toggle-handshake memory responder plus a transaction-order model.
`timescale 1ns/1ps
module tb_rom_fetch_sched;
  localparam int NC = 6;
  localparam int AW = 16;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              dl_active, dl_wr;
  logic [23:0]       dl_addr;
  logic [7:0]        dl_data;
  logic [NC*AW-1:0]  cli_addr;
  logic [NC*16-1:0]  cli_q;
  logic [NC-1:0]     cli_valid;
  logic              mem_req, mem_ack, mem_we;
  logic [22:0]       mem_a;
  logic [1:0]        mem_ds;
  logic [15:0]       mem_d, mem_q;
  logic              busy, dl_overflow;

  always #5 clk_sys = ~clk_sys;

  rom_fetch_sched #(.NCLIENTS(NC), .AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .cli_addr(cli_addr), .cli_q(cli_q),
    .cli_valid(cli_valid), .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we),
    .mem_a(mem_a), .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q), .busy(busy),
    .dl_overflow(dl_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  // Word memory: written words are stored, untouched words read back a fixed address hash.
  logic [15:0] mem_words [int];
  function automatic logic [15:0] mem_rd(input logic [22:0] a);
    if (mem_words.exists(int'(a))) return mem_words[int'(a)];
    return {a[7:0], a[15:8]} ^ 16'h6C3A ^ {9'h0, a[22:16]};
  endfunction

  typedef struct packed {
    logic        we;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } tx_t;

  tx_t txq[$];
  int  ack_delay = 0;
  bit  hold_ack  = 1'b0;
  bit  rsp_busy  = 1'b0;
  int  rsp_cnt   = 0;
  tx_t rsp_tx;

  always @(negedge clk_sys) begin
    if (reset) begin
      rsp_busy = 1'b0;
    end else if (!rsp_busy) begin
      if (mem_req != mem_ack) begin
        rsp_tx.we = mem_we;
        rsp_tx.a  = mem_a;
        rsp_tx.ds = mem_ds;
        rsp_tx.d  = mem_d;
        txq.push_back(rsp_tx);
        rsp_cnt  = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 4));
        rsp_busy = 1'b1;
        $display("tx we=%0d a=%06h ds=%b d=%04h", mem_we, mem_a, mem_ds, mem_d);
      end
    end else if (!hold_ack) begin
      rsp_cnt--;
      if (rsp_cnt <= 0) begin
        check_eq("hold_a", 32'(mem_a), 32'(rsp_tx.a));
        check_eq("hold_we", 32'(mem_we), 32'(rsp_tx.we));
        if (rsp_tx.we) begin
          logic [15:0] w;
          w = mem_rd(rsp_tx.a);
          if (rsp_tx.ds[1]) w[15:8] = rsp_tx.d[15:8];
          if (rsp_tx.ds[0]) w[7:0]  = rsp_tx.d[7:0];
          mem_words[int'(rsp_tx.a)] = w;
        end else begin
          mem_q = mem_rd(rsp_tx.a);
        end
        mem_ack  = mem_req;
        rsp_busy = 1'b0;
      end
    end
  end

  logic [AW-1:0] mtag [NC];
  bit            mvalid [NC];
  int            last_gnt = NC - 1;

  task automatic set_cli(input int i, input logic [AW-1:0] v);
    cli_addr[i*AW +: AW] = v;
  endtask

  function automatic logic [AW-1:0] get_cli(input int i);
    return cli_addr[i*AW +: AW];
  endfunction

  task automatic wait_tx(output tx_t t, output bit ok);
    ok = 1'b0;
    t  = '0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (txq.size() > 0) begin
        t  = txq.pop_front();
        ok = 1'b1;
      end else begin
        tick();
      end
    end
    if (!ok) check_eq("tx_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (busy && c < 200) begin
      tick();
      c++;
    end
    check_eq({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Pending clients are granted in circular order from one past the last grant (ascending when fixed).
  task automatic read_round(input string nm);
    int  order[$];
    tx_t t;
    bit  ok;
`ifdef ROMSCHED_FIXED_PRIO_EN
    for (int k = 0; k < NC; k++)
      if (!mvalid[k] || mtag[k] != get_cli(k)) order.push_back(k);
`else
    for (int k = 1; k <= NC; k++) begin
      int c;
      c = (last_gnt + k) % NC;
      if (!mvalid[c] || mtag[c] != get_cli(c)) order.push_back(c);
    end
`endif
    foreach (order[j]) begin
      wait_tx(t, ok);
      if (ok) begin
        check_eq({nm, "_rd_we"}, 32'(t.we), 32'd0);
        check_eq({nm, "_rd_a"}, 32'(t.a), 32'(get_cli(order[j])));
        check_eq({nm, "_rd_ds"}, 32'(t.ds), 32'd3);
      end
    end
    if (order.size() > 0) last_gnt = order[order.size() - 1];
    wait_idle(nm);
    tick(4);
    check_eq({nm, "_extra_tx"}, 32'(txq.size()), 32'd0);
    for (int k = 0; k < NC; k++) begin
      check_eq({nm, "_valid"}, 32'(cli_valid[k]), 32'd1);
      check_eq({nm, "_q"}, 32'(cli_q[k*16 +: 16]), 32'(mem_rd(23'(get_cli(k)))));
      mtag[k]   = get_cli(k);
      mvalid[k] = 1'b1;
    end
  endtask

  task automatic pulse_byte(input logic [23:0] a, input logic [7:0] d);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    tick();
    dl_wr   = 1'b0;
    tick();
  endtask

  task automatic check_write(input string nm, input logic [23:0] a, input logic [7:0] d);
    tx_t t;
    bit  ok;
    wait_tx(t, ok);
    if (ok) begin
      check_eq({nm, "_we"}, 32'(t.we), 32'd1);
      check_eq({nm, "_a"}, 32'(t.a), 32'(a[23:1]));
      check_eq({nm, "_ds"}, 32'(t.ds), 32'({a[0], ~a[0]}));
      check_eq({nm, "_d"}, 32'(t.d), 32'({d, d}));
    end
  endtask

  initial begin : main
    logic [AW-1:0] a1, a2;
    logic [23:0]   ba [4];
    logic [7:0]    bd [4];
    logic [5:0]    mask;
    int            c;

    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_q     = 16'h0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    for (int i = 0; i < NC; i++) begin
      set_cli(i, AW'($urandom));
      mvalid[i] = 1'b0;
      mtag[i]   = '0;
    end
    tick(3);
    check_eq("rst_req", 32'(mem_req), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(cli_valid), 32'd0);
    check_eq("rst_ovf", 32'(dl_overflow), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_a", 32'(mem_a), 32'd0);
    check_eq("rst_ds", 32'(mem_ds), 32'd3);
    check_eq("rst_d", 32'(mem_d), 32'd0);
    check_eq("rst_q2", 32'(cli_q[2*16 +: 16]), 32'd0);

    set_cli(2, 16'h0123);
    mem_words[32'h123] = 16'hBEEF;
    reset     = 1'b0;
    ack_delay = 3;
    read_round("miss");
    check_eq("miss_q2", 32'(cli_q[2*16 +: 16]), 32'h0000BEEF);
    read_round("hit");

    ack_delay = 0;
    foreach (ba[i]) ba[i] = '0;
    set_cli(0, get_cli(0) ^ AW'($urandom_range(1, 65535)));
    set_cli(1, get_cli(1) ^ AW'($urandom_range(1, 65535)));
    set_cli(3, get_cli(3) ^ AW'($urandom_range(1, 65535)));
    read_round("rr");

    for (int r = 0; r < 6; r++) begin
      mask = 6'($urandom_range(1, 63));
      for (int i = 0; i < NC; i++)
        if (mask[i]) set_cli(i, AW'($urandom));
      read_round("rand");
    end

    dl_active = 1'b1;
    tick(2);
    check_eq("dl_rise_valid", 32'(cli_valid), 32'd0);
    pulse_byte(24'h000011, 8'hA5);
    check_write("dlw0", 24'h000011, 8'hA5);
    for (int j = 0; j < 5; j++) begin
      ba[0] = {7'h0, get_cli(j % NC), 1'($urandom)};
      bd[0] = 8'($urandom);
      pulse_byte(ba[0], bd[0]);
      check_write("dlw", ba[0], bd[0]);
      tick(6);
    end
    tick(10);
    check_eq("dl_no_reads", 32'(txq.size()), 32'd0);
    check_eq("dl_idle", 32'(busy), 32'd0);
    dl_active = 1'b0;
    tick();
    check_eq("dl_fall_valid", 32'(cli_valid), 32'd0);
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    read_round("refetch");

    a1 = get_cli(0) ^ 16'h00F0;
    a2 = a1 ^ 16'h1001;
    hold_ack = 1'b1;
    set_cli(0, a1);
    begin
      tx_t t;
      bit  ok;
      wait_tx(t, ok);
      if (ok) check_eq("chg_a1", 32'(t.a), 32'(a1));
    end
    set_cli(0, a2);
    tick(2);
    hold_ack = 1'b0;
    c = 0;
    do begin
      tick();
      c++;
    end while (busy && c < 50);
    check_eq("chg_busy", 32'(busy), 32'd0);
    check_eq("chg_valid0", 32'(cli_valid[0]), 32'd0);
    mtag[0]   = a1;
    mvalid[0] = 1'b1;
    last_gnt  = 0;
    read_round("chg");

    dl_active = 1'b1;
    tick(2);
    hold_ack = 1'b1;
    for (int j = 0; j < 4; j++) begin
      ba[j] = 24'($urandom);
      bd[j] = 8'($urandom);
      pulse_byte(ba[j], bd[j]);
      if (j == 2) check_eq("ovf_after3", 32'(dl_overflow), 32'd0);
    end
    check_eq("ovf_after4", 32'(dl_overflow), 32'd1);
    hold_ack = 1'b0;
    check_write("ovw0", ba[0], bd[0]);
    check_write("ovw1", ba[1], bd[1]);
    check_write("ovw2", ba[2], bd[2]);
    tick(12);
    check_eq("ovf_dropped", 32'(txq.size()), 32'd0);
    check_eq("ovf_sticky", 32'(dl_overflow), 32'd1);
    dl_active = 1'b0;
    tick();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    read_round("reflow");
    check_eq("ovf_sticky2", 32'(dl_overflow), 32'd1);

    reset = 1'b1;
    tick(2);
    check_eq("rst2_ovf", 32'(dl_overflow), 32'd0);
    check_eq("rst2_req", 32'(mem_req), 32'(mem_ack));
    check_eq("rst2_valid", 32'(cli_valid), 32'd0);
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
